// File: rtl/vh_pkg.sv
// vh_pkg: shared definitions for the vloghammer signature compactor and
// related checkers.
//   state_e  : compactor FSM states
//   SIG_W    : signature width
//   POLY     : default MISR feedback polynomial
//   SIG_SEED : signature value at the start of every run (all ones)
package vh_pkg;

  localparam int unsigned SIG_W = 32;
  localparam logic [SIG_W-1:0] POLY = 32'h04C11DB7;
  localparam logic [SIG_W-1:0] SIG_SEED = '1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

endpackage

// File: rtl/vh_misr_step.sv
// vh_misr_step: combinational MISR step. Folds a Y_W-bit vector into one
// SIG_W-bit word by zero-extending it to a whole number of words and XORing
// the words together, then advances the signature by one Galois shift.
// Ports:
//   sig      in  SIG_W  current signature
//   y        in  Y_W    vector to absorb
//   next_sig out SIG_W  signature after absorbing y
module vh_misr_step #(
  parameter int unsigned Y_W   = 90,
  parameter int unsigned SIG_W = 32,
  parameter logic [SIG_W-1:0] POLY = 32'h04C11DB7
) (
  input  logic [SIG_W-1:0] sig,
  input  logic [Y_W-1:0]   y,
  output logic [SIG_W-1:0] next_sig
);

  localparam int unsigned NW = (Y_W + SIG_W - 1) / SIG_W;

  logic [NW*SIG_W-1:0] y_ext;
  logic [SIG_W-1:0]    fold;

  // Bit i aliases with bits i+SIG_W, i+2*SIG_W, ... by design: the fold only
  // has to be sensitive to every input bit, not injective.
  always_comb begin
    // NOTE: every variable assigned in always_comb gets a value first on every
    // path, otherwise synthesis infers a latch to hold the old value.
    y_ext = '0;
    y_ext[Y_W-1:0] = y;
    fold = '0;
    for (int i = 0; i < int'(NW); i++) begin
      fold = fold ^ y_ext[i*SIG_W +: SIG_W];
    end
    next_sig = {sig[SIG_W-2:0], 1'b0} ^ (sig[SIG_W-1] ? POLY : '0) ^ fold;
  end

endmodule

// File: rtl/vh_sig_compactor.sv
// vh_sig_compactor: capture stage for expression_* blocks. Absorbs num_vec
// result vectors into a MISR signature and compares it with exp_sig.
// Ports:
//   clk, rst_n       clock, asynchronous active-low reset
//   start            one-cycle pulse; starts a run from IDLE or DONE
//   num_vec, exp_sig run length and expected signature, sampled at start
//   in_valid/in_ready/in_y  vector input handshake
//   busy             run in progress (RUN or DRAIN)
//   done, pass       run complete; pass = (sig == exp_sig), held until start
//   sig              current signature
//   vec_cnt          vectors accepted in this run
module vh_sig_compactor
  import vh_pkg::*;
#(
  parameter int unsigned Y_W   = 90,
  parameter int unsigned SIG_W = vh_pkg::SIG_W,
  parameter logic [SIG_W-1:0] POLY = vh_pkg::POLY,
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [CNT_W-1:0] num_vec,
  input  logic [SIG_W-1:0] exp_sig,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [Y_W-1:0]   in_y,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [SIG_W-1:0] sig,
  output logic [CNT_W-1:0] vec_cnt
);

  localparam logic [SIG_W-1:0] SEED = {SIG_W{1'b1}};

  state_e           state_q, state_d;
  logic [CNT_W-1:0] num_vec_q;
  logic [SIG_W-1:0] exp_sig_q;
  logic [SIG_W-1:0] sig_q;
  logic [CNT_W-1:0] vec_cnt_q;
  logic             pass_q;
  logic [Y_W-1:0]   hold_y;
  logic             hold_valid;
  logic [SIG_W-1:0] sig_step;

  logic start_ok;
  logic xfer;
  logic last_xfer;

  assign start_ok  = start && (state_q == ST_IDLE || state_q == ST_DONE);
  assign xfer      = in_valid && in_ready;
  assign last_xfer = xfer && (vec_cnt_q == num_vec_q - CNT_W'(1));

  vh_misr_step #(
    .Y_W  (Y_W),
    .SIG_W(SIG_W),
    .POLY (POLY)
  ) u_step (
    .sig     (sig_q),
    .y       (hold_y),
    .next_sig(sig_step)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential blocks use non-blocking (<=) so every flop samples the
    // pre-edge values regardless of statement order.
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // Next state and state-decoded outputs.
  always_comb begin
    state_d  = state_q;
    in_ready = 1'b0;
    busy     = 1'b0;
    done     = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (start_ok) state_d = (num_vec == '0) ? ST_DONE : ST_RUN;
      end
      ST_RUN: begin
        in_ready = 1'b1;
        busy     = 1'b1;
        if (last_xfer) state_d = ST_DRAIN;
      end
      ST_DRAIN: begin
        busy    = 1'b1;
        state_d = ST_DONE;
      end
      ST_DONE: begin
        done = 1'b1;
        if (start_ok) state_d = (num_vec == '0) ? ST_DONE : ST_RUN;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Run configuration, counters, signature and verdict.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      num_vec_q  <= '0;
      exp_sig_q  <= '0;
      sig_q      <= '0;
      vec_cnt_q  <= '0;
      pass_q     <= 1'b0;
      hold_valid <= 1'b0;
    end else if (start_ok) begin
      num_vec_q  <= num_vec;
      exp_sig_q  <= exp_sig;
      sig_q      <= SEED;
      vec_cnt_q  <= '0;
      hold_valid <= 1'b0;
      // An empty run enters DONE immediately, so its verdict is formed now.
      pass_q     <= (num_vec == '0) && (exp_sig == SEED);
    end else begin
      hold_valid <= xfer;
      if (xfer)       vec_cnt_q <= vec_cnt_q + CNT_W'(1);
      if (hold_valid) sig_q     <= sig_step;
      // DRAIN always holds the final vector; judge the signature it produces.
      if (state_q == ST_DRAIN) pass_q <= (sig_step == exp_sig_q);
    end
  end

  // NOTE: the hold data register has no reset; hold_valid qualifies it, so
  // its contents after reset never reach sig.
  always_ff @(posedge clk) begin
    if (xfer) hold_y <= in_y;
  end

  assign sig     = sig_q;
  assign vec_cnt = vec_cnt_q;
  assign pass    = pass_q;

endmodule

// File: tb/tb_vh_sig_compactor.sv
module tb_vh_sig_compactor;

  localparam int Y_W   = 90;
  localparam int SIG_W = 32;
  localparam int CNT_W = 16;

  logic             clk;
  logic             rst_n;
  logic             start;
  logic [CNT_W-1:0] num_vec;
  logic [SIG_W-1:0] exp_sig;
  logic             in_valid;
  logic             in_ready;
  logic [Y_W-1:0]   in_y;
  logic             busy;
  logic             done;
  logic             pass;
  logic [SIG_W-1:0] sig;
  logic [CNT_W-1:0] vec_cnt;

  int checks;
  int errors;

  typedef struct {
    logic [SIG_W-1:0] sig;
    logic [CNT_W-1:0] cnt;
    logic             pass;
  } exp_t;

  exp_t           sb[$];
  logic [Y_W-1:0] vec_q[$];

  vh_sig_compactor dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .num_vec (num_vec),
    .exp_sig (exp_sig),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .in_y    (in_y),
    .busy    (busy),
    .done    (done),
    .pass    (pass),
    .sig     (sig),
    .vec_cnt (vec_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Reference MISR step, written from the behavioural description.
  function automatic logic [31:0] model_step(logic [31:0] s, logic [89:0] y);
    logic [95:0] e;
    logic [31:0] f;
    e = {6'b0, y};
    f = e[31:0] ^ e[63:32] ^ e[95:64];
    return {s[30:0], 1'b0} ^ (s[31] ? 32'h04C11DB7 : 32'h0) ^ f;
  endfunction

  // Pulse start at the next falling edge and push the expected outcome,
  // computed from vec_q, onto the scoreboard.
  task automatic start_run(input logic [CNT_W-1:0] n, input logic [SIG_W-1:0] e);
    exp_t x;
    logic [31:0] s;
    s = 32'hFFFFFFFF;
    for (int i = 0; i < int'(n); i++) s = model_step(s, vec_q[i]);
    x.sig  = s;
    x.cnt  = n;
    x.pass = (s == e);
    sb.push_back(x);
    @(negedge clk);
    start   = 1'b1;
    num_vec = n;
    exp_sig = e;
  endtask

  task automatic compare_done(input string name);
    exp_t x;
    checks++;
    if (sb.size() == 0) begin
      errors++;
      $display("FAIL %s: scoreboard empty at done", name);
    end else begin
      x = sb.pop_front();
      if (sig !== x.sig || vec_cnt !== x.cnt || pass !== x.pass) begin
        errors++;
        $display("FAIL %s: got sig=%h cnt=%0d pass=%b, want sig=%h cnt=%0d pass=%b",
                 name, sig, vec_cnt, pass, x.sig, x.cnt, x.pass);
      end
    end
  endtask

  // Feed n vectors from vec_q (optionally with random gaps and a stray start
  // mid-run), then check in_ready drop and done latency, then the scoreboard.
  task automatic feed_and_check(input int n, input bit gaps, input bit mid_start,
                                input string name);
    int  i;
    int  cyc;
    bit  v;
    i   = 0;
    cyc = 0;
    while (i < n) begin
      @(negedge clk);
      start = 1'b0;
      if (cyc > 200) begin
        checks++;
        errors++;
        $display("FAIL %s: transfer budget expired, accepted %0d of %0d", name, i, n);
        break;
      end
      cyc++;
      v = gaps ? ($urandom_range(0, 2) != 0) : 1'b1;
      if (mid_start && i == 2) begin
        start   = 1'b1;
        num_vec = 16'd1;
        exp_sig = 32'h0;
      end
      in_valid = v;
      in_y     = vec_q[i];
      if (v && in_ready) i++;
    end
    @(negedge clk);
    start    = 1'b0;
    in_valid = 1'b0;
    checks++;
    if (in_ready !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL %s_drain: in_ready=%b done=%b, want 0 0", name, in_ready, done);
    end
    @(negedge clk);
    checks++;
    if (done !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL %s_done_latency: done=%b busy=%b, want 1 0", name, done, busy);
    end
    compare_done(name);
  endtask

  task automatic test_reset;
    rst_n = 1'b0; start = 1'b0; num_vec = '0; exp_sig = '0;
    in_valid = 1'b0; in_y = '0;
    repeat (2) @(negedge clk);
    checks++;
    if ({in_ready, busy, done, pass} !== 4'b0 || sig !== '0 || vec_cnt !== '0) begin
      errors++;
      $display("FAIL reset: rdy=%b busy=%b done=%b pass=%b sig=%h cnt=%0d, want all 0",
               in_ready, busy, done, pass, sig, vec_cnt);
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_zero_vec;
    vec_q = {};
    start_run(16'd0, 32'hFFFFFFFF);
    @(negedge clk);
    start = 1'b0;
    checks++;
    if (done !== 1'b1 || sig !== 32'hFFFFFFFF) begin
      errors++;
      $display("FAIL zero_vec: done=%b sig=%h, want 1 ffffffff", done, sig);
    end
    compare_done("zero_vec");
  endtask

  task automatic test_single;
    vec_q = {90'd0};
    start_run(16'd1, 32'hFB3EE249);
    feed_and_check(1, 1'b0, 1'b0, "single_pass");
    checks++;
    if (sig !== 32'hFB3EE249 || pass !== 1'b1) begin
      errors++;
      $display("FAIL single_const: sig=%h pass=%b, want fb3ee249 1", sig, pass);
    end
    start_run(16'd1, 32'h0);
    feed_and_check(1, 1'b0, 1'b0, "single_nopass");
    checks++;
    if (pass !== 1'b0) begin
      errors++;
      $display("FAIL single_nopass_const: pass=%b, want 0", pass);
    end
  endtask

  task automatic test_alias;
    logic [Y_W-1:0] t;
    t = '0; t[0] = 1'b1;
    vec_q = {t};
    start_run(16'd1, 32'hFB3EE248);
    feed_and_check(1, 1'b0, 1'b0, "alias_bit0");
    t = '0; t[64] = 1'b1;
    vec_q = {t};
    start_run(16'd1, 32'hFB3EE248);
    feed_and_check(1, 1'b0, 1'b0, "alias_bit64");
    checks++;
    if (sig !== 32'hFB3EE248 || pass !== 1'b1) begin
      errors++;
      $display("FAIL alias_const: sig=%h pass=%b, want fb3ee248 1", sig, pass);
    end
  endtask

  task automatic fill_random(input int n);
    logic [Y_W-1:0] t;
    vec_q = {};
    for (int i = 0; i < n; i++) begin
      t = {$urandom(), $urandom(), $urandom()};
      vec_q.push_back(t);
    end
  endtask

  task automatic test_random_gaps;
    for (int r = 0; r < 3; r++) begin
      fill_random(4);
      start_run(16'd4, (r == 0) ? 32'h0 : 32'h12345678);
      feed_and_check(4, 1'b1, 1'b0, "random_gaps");
    end
  endtask

  task automatic test_start_ignored;
    fill_random(4);
    start_run(16'd4, 32'h0);
    feed_and_check(4, 1'b1, 1'b1, "mid_start");
  endtask

  task automatic test_reset_mid_run;
    int acc;
    int cyc;
    fill_random(4);
    @(negedge clk);
    start = 1'b1; num_vec = 16'd4; exp_sig = 32'h0;
    acc = 0;
    cyc = 0;
    while (acc < 2 && cyc < 50) begin
      @(negedge clk);
      start = 1'b0;
      in_valid = 1'b1;
      in_y = vec_q[acc];
      if (in_ready) acc++;
      cyc++;
    end
    @(negedge clk);
    in_y = vec_q[2];
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({in_ready, busy, done, pass} !== 4'b0 || sig !== '0 || vec_cnt !== '0) begin
      errors++;
      $display("FAIL reset_mid_run: rdy=%b busy=%b done=%b pass=%b sig=%h cnt=%0d, want all 0",
               in_ready, busy, done, pass, sig, vec_cnt);
    end
    @(negedge clk);
    in_valid = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || sig !== '0) begin
      errors++;
      $display("FAIL reset_idle: busy=%b sig=%h, want 0 0", busy, sig);
    end
    fill_random(4);
    start_run(16'd4, 32'h0);
    feed_and_check(4, 1'b0, 1'b0, "after_reset");
  endtask

  task automatic test_back_to_back;
    fill_random(2);
    start_run(16'd2, 32'h0);
    feed_and_check(2, 1'b0, 1'b0, "b2b_first");
    fill_random(3);
    start_run(16'd3, 32'h0);
    @(negedge clk);
    start = 1'b0;
    checks++;
    if (done !== 1'b0 || sig !== 32'hFFFFFFFF || vec_cnt !== '0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL b2b_restart: done=%b sig=%h cnt=%0d busy=%b, want 0 ffffffff 0 1",
               done, sig, vec_cnt, busy);
    end
    feed_and_check(3, 1'b0, 1'b0, "b2b_second");
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_zero_vec();
    test_single();
    test_alias();
    test_random_gaps();
    test_start_ignored();
    test_reset_mid_run();
    test_back_to_back();
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: %0d entries left, want 0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
